trap_commit: RTL

Commit-side partner of the pipeline trap unit. It accepts a registered trap request (exception or interrupt), saves machine trap state (mepc, mcause, mstatus stacking), switches privilege mode and issues a one-cycle-registered pipeline flush with redirect PC. It also executes MRET, owns mtvec, and feeds the vector configuration and interrupt-enable gate back to the trap unit.

---
 rtl/trap_commit_pkg.sv | 37 +++
 rtl/trap_commit_if.sv | 37 +++
 rtl/trap_csr_regs.sv | 82 ++++++++
 rtl/trap_commit.sv | 116 +++++++++++
 4 files changed

// File: rtl/trap_commit_pkg.sv
// Shared constants, FSM encoding and the latched trap-request payload for trap_commit.
package trap_commit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned MODE_W  = 2;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [MODE_W-1:0] MODE_U = 2'b00;
  localparam logic [MODE_W-1:0] MODE_S = 2'b01;
  localparam logic [MODE_W-1:0] MODE_M = 2'b11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_JUMP    = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   code;
    logic [XLEN-1:0]   jmp_to;
    logic              chmode_do;
    logic [MODE_W-1:0] chmode_to;
  } trap_req_t;

endpackage

// File: rtl/trap_commit_if.sv
// Trap-unit / pipeline side bus of trap_commit: requests, CSR port and redirect outputs.
interface trap_commit_if;
  import trap_commit_pkg::*;

  logic                mmu_wait;
  logic                trap_en;
  logic [XLEN-1:0]     trap_pc;
  logic [XLEN-1:0]     trap_code;
  logic [XLEN-1:0]     trap_jmp_to;
  logic                chmode_do;
  logic [MODE_W-1:0]   chmode_to;
  logic                mret_en;
  logic                csr_wen;
  logic [CSR_AW-1:0]   csr_waddr;
  logic [XLEN-1:0]     csr_wdata;
  logic [CSR_AW-1:0]   csr_raddr;
  logic [XLEN-1:0]     csr_rdata;
  logic [1:0]          trap_vec_mode;
  logic [XLEN-1:0]     trap_vec_base;
  logic                int_allow;
  logic [MODE_W-1:0]   mode;
  logic                flush;
  logic [XLEN-1:0]     new_pc;
  logic                busy;

  modport master (
    output mmu_wait, trap_en, trap_pc, trap_code, trap_jmp_to, chmode_do, chmode_to,
           mret_en, csr_wen, csr_waddr, csr_wdata, csr_raddr,
    input  csr_rdata, trap_vec_mode, trap_vec_base, int_allow, mode, flush, new_pc, busy
  );

  modport slave (
    input  mmu_wait, trap_en, trap_pc, trap_code, trap_jmp_to, chmode_do, chmode_to,
           mret_en, csr_wen, csr_waddr, csr_wdata, csr_raddr,
    output csr_rdata, trap_vec_mode, trap_vec_base, int_allow, mode, flush, new_pc, busy
  );
endinterface

// File: rtl/trap_csr_regs.sv
// Machine trap CSR storage (mstatus/mtvec/mepc/mcause) with write port, trap save/restore and read mux.
module trap_csr_regs
  import trap_commit_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wen,
  input  logic [CSR_AW-1:0]   waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [CSR_AW-1:0]   raddr,
  output logic [XLEN-1:0]     rdata,
  input  logic                save,
  input  logic [XLEN-1:0]     save_pc,
  input  logic [XLEN-1:0]     save_code,
  input  logic [MODE_W-1:0]   save_mode,
  input  logic                restore,
  output logic                mie,
  output logic [MODE_W-1:0]   mpp,
  output logic [XLEN-1:0]     mepc,
  output logic [XLEN-1:0]     mtvec
);

  logic            mpie;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mstatus;

  // Trap save/restore take precedence; the FSM never raises them together with wen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mpp    <= MODE_U;
      mepc   <= '0;
      mcause <= '0;
      mtvec  <= '0;
    end else if (en) begin
      if (save) begin
        mepc   <= {save_pc[XLEN-1:2], 2'b00};
        mcause <= save_code;
        mpie   <= mie;
        mie    <= 1'b0;
        mpp    <= save_mode;
      end else if (restore) begin
        mie    <= mpie;
        mpie   <= 1'b1;
        mpp    <= MODE_U;
      end else if (wen) begin
        case (waddr)
          CSR_MSTATUS: begin
            mie  <= wdata[MSTATUS_MIE];
            mpie <= wdata[MSTATUS_MPIE];
            mpp  <= wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end
          CSR_MTVEC:  mtvec  <= wdata;
          CSR_MEPC:   mepc   <= {wdata[XLEN-1:2], 2'b00};
          CSR_MCAUSE: mcause <= wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mstatus = '0;
    mstatus[MSTATUS_MIE]                   = mie;
    mstatus[MSTATUS_MPIE]                  = mpie;
    mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CSR_MSTATUS: rdata = mstatus;
      CSR_MTVEC:   rdata = mtvec;
      CSR_MEPC:    rdata = mepc;
      CSR_MCAUSE:  rdata = mcause;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/trap_commit.sv
// Trap commit: sequences trap entry / MRET, switches privilege and issues a registered flush + redirect.
module trap_commit
  import trap_commit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  trap_commit_if.slave bus
);

  state_e            state, state_nxt;
  trap_req_t         req;
  logic              go;
  logic              accept_trap;
  logic              csr_we;
  logic              do_save;
  logic              do_restore;
  logic [MODE_W-1:0] mode;
  logic              flush;
  logic              int_allow;
  logic [XLEN-1:0]   new_pc;
  logic              mie;
  logic [MODE_W-1:0] mpp;
  logic [XLEN-1:0]   mepc;
  logic [XLEN-1:0]   mtvec;

  assign go = !bus.mmu_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= ST_IDLE;
    else if (go) state <= state_nxt;
  end

  // Trap beats MRET; CSR writes only land in an otherwise quiet IDLE cycle.
  always_comb begin
    state_nxt   = state;
    accept_trap = 1'b0;
    csr_we      = 1'b0;
    do_save     = 1'b0;
    do_restore  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.trap_en) begin
          accept_trap = 1'b1;
          state_nxt   = ST_SAVE;
        end else if (bus.mret_en) begin
          state_nxt   = ST_RESTORE;
        end else begin
          csr_we      = bus.csr_wen;
        end
      end
      ST_SAVE: begin
        do_save   = 1'b1;
        state_nxt = ST_JUMP;
      end
      ST_RESTORE: begin
        do_restore = 1'b1;
        state_nxt  = ST_JUMP;
      end
      ST_JUMP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req       <= '0;
      mode      <= MODE_M;
      new_pc    <= '0;
      flush     <= 1'b0;
      int_allow <= 1'b0;
    end else if (go) begin
      if (accept_trap) begin
        req <= '{pc: bus.trap_pc, code: bus.trap_code, jmp_to: bus.trap_jmp_to,
                 chmode_do: bus.chmode_do, chmode_to: bus.chmode_to};
      end
      if (do_save) begin
        mode   <= req.chmode_do ? req.chmode_to : MODE_M;
        new_pc <= req.jmp_to;
      end else if (do_restore) begin
        mode   <= mpp;
        new_pc <= mepc;
      end
      flush     <= (state == ST_JUMP);
      int_allow <= (mode != MODE_M) || mie;
    end
  end

  trap_csr_regs u_csr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (go),
    .wen       (csr_we),
    .waddr     (bus.csr_waddr),
    .wdata     (bus.csr_wdata),
    .raddr     (bus.csr_raddr),
    .rdata     (bus.csr_rdata),
    .save      (do_save),
    .save_pc   (req.pc),
    .save_code (req.code),
    .save_mode (mode),
    .restore   (do_restore),
    .mie       (mie),
    .mpp       (mpp),
    .mepc      (mepc),
    .mtvec     (mtvec)
  );

  assign bus.mode          = mode;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.int_allow     = int_allow;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.trap_vec_mode = mtvec[1:0];
  assign bus.trap_vec_base = {mtvec[XLEN-1:2], 2'b00};

endmodule
